// File: rtl/mega_alu_commit_pkg.sv
// mega_alu_commit_pkg: shared state encodings, SREG I/O address and XMEGA flag bit indices
package mega_alu_commit_pkg;

    typedef enum logic [1:0] {
        COMMIT_IDLE  = 2'd0,
        COMMIT_WR_LO = 2'd1,
        COMMIT_WR_HI = 2'd2
    } commit_state_t;

    localparam logic [5:0] SREG_IO_ADDR = 6'h3F;

    localparam int XMEGA_FLAG_C = 0;
    localparam int XMEGA_FLAG_Z = 1;
    localparam int XMEGA_FLAG_N = 2;
    localparam int XMEGA_FLAG_V = 3;
    localparam int XMEGA_FLAG_S = 4;
    localparam int XMEGA_FLAG_H = 5;
    localparam int XMEGA_FLAG_T = 6;
    localparam int XMEGA_FLAG_I = 7;

endpackage

// File: rtl/mega_alu_commit.sv
// mega_alu_commit: ALU writeback stage owning SREG and writing 8/16-bit results through an acked 8-bit port
module mega_alu_commit
    import mega_alu_commit_pkg::*;
#(
    parameter int         REG_ADDR_W = 5,
    parameter logic [7:0] SREG_RST   = 8'h00,
    parameter             FORWARD    = "TRUE"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rda,
    input  logic [15:0]           in_r,
    input  logic [7:0]            in_sreg,
    input  logic                  in_wr8,
    input  logic                  in_wr16,
    input  logic                  in_wr_sreg,
    input  logic                  io_sreg_wr,
    input  logic [7:0]            io_sreg_data,
    output logic [7:0]            sreg,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [7:0]            rf_data,
    input  logic                  rf_ack,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [7:0]            fwd_data
);

    commit_state_t         state, nxt_state;
    logic [REG_ADDR_W-1:0] nxt_addr;
    logic [7:0]            nxt_data;
    logic [7:0]            hi_byte;
    logic                  pair;
    logic                  accept;

    assign accept = in_valid & in_ready;

    // Next state and the next values of the registered write port; rf_ack only steers the transition
    always_comb begin
        nxt_state = state;
        nxt_addr  = rf_addr;
        nxt_data  = rf_data;
        case (state)
            COMMIT_IDLE: begin
                if (accept && (in_wr8 || in_wr16)) begin
                    nxt_state = COMMIT_WR_LO;
                    nxt_addr  = in_wr16 ? {in_rda[REG_ADDR_W-1:1], 1'b0} : in_rda;
                    nxt_data  = in_r[7:0];
                end
            end
            COMMIT_WR_LO: begin
                if (rf_ack) begin
                    nxt_state = pair ? COMMIT_WR_HI : COMMIT_IDLE;
                    nxt_addr  = pair ? {rf_addr[REG_ADDR_W-1:1], 1'b1} : rf_addr;
                    nxt_data  = pair ? hi_byte : rf_data;
                end
            end
            COMMIT_WR_HI: nxt_state = rf_ack ? COMMIT_IDLE : state;
            default:      nxt_state = COMMIT_IDLE;
        endcase
    end

    // State, registered write port and the captured high byte; reset drops any write in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= COMMIT_IDLE;
            in_ready <= 1'b1;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            pair     <= 1'b0;
            hi_byte  <= '0;
        end else begin
            state    <= nxt_state;
            in_ready <= nxt_state == COMMIT_IDLE;
            rf_we    <= nxt_state != COMMIT_IDLE;
            rf_addr  <= nxt_addr;
            rf_data  <= nxt_data;
            if (accept) begin
                pair    <= in_wr16;
                hi_byte <= in_r[15:8];
            end
        end
    end

    // Architectural SREG: an I/O-bus write overrides a same-cycle ALU flag commit
    always_ff @(posedge clk) begin
        if (!rst)
            sreg <= SREG_RST;
        else if (io_sreg_wr)
            sreg <= io_sreg_data;
        else if (accept && in_wr_sreg)
            sreg <= in_sreg;
    end

    if (FORWARD == "TRUE") begin : g_fwd
        assign fwd_valid = rf_we;
        assign fwd_addr  = rf_addr;
        assign fwd_data  = rf_data;
    end else begin : g_no_fwd
        assign fwd_valid = 1'b0;
        assign fwd_addr  = '0;
        assign fwd_data  = '0;
    end

endmodule
